psum_accumulator: RTL and testbench



---
 rtl/psum_accumulator.sv | 119 +++++++++++
 tb/tb_psum_accumulator.sv | 139 +++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates signed shift-add results over a configurable
// window and presents one wide partial sum per window on a valid/ready port.
// Optional feature macro: PSUM_ACC_SAT_EN. When it is defined, the accumulator
// saturates on signed overflow. When it is undefined, the accumulator wraps.
// out_ovf reports overflow in both builds.
module psum_accumulator #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [LEN_W:0]       LEN_MAX = (LEN_W+1)'(1) << LEN_W;
  localparam logic [LEN_W:0]       ONE     = (LEN_W+1)'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [LEN_W:0]          cnt, len_q;
  logic                    ovf_acc;

  logic                    accept, start, last;
  logic [LEN_W:0]          len_new, cnt_inc;
  logic signed [ACC_W-1:0] in_ext, acc_nxt;
  logic signed [ACC_W:0]   sum;
  logic                    ovf;

  // Handshake, window-length decode and the widened add with overflow detect
  always_comb begin
    accept  = in_valid && in_ready;
    start   = accept && (state != ACCUM);
    len_new = (cfg_len == '0) ? LEN_MAX : {1'b0, cfg_len};
    cnt_inc = cnt + ONE;
    last    = (cnt_inc == len_q);
    in_ext  = ACC_W'(in_data);
    sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(in_ext);
    ovf     = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef PSUM_ACC_SAT_EN
    // The true sign is in the extra MSB, so it picks the clamp direction
    if (ovf) acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else     acc_nxt = sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state. A start from DONE reuses the IDLE path, which allows
  // back-to-back windows of length 1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (len_new == ONE) ? DONE : ACCUM;
      ACCUM:   if (accept && last) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = (len_new == ONE) ? DONE : ACCUM;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. in_ready depends combinationally on out_ready only in DONE.
  always_comb begin
    out_valid = (state == DONE);
    busy      = (state == ACCUM);
    in_ready  = (state != DONE) || out_ready;
  end

  // Datapath: the accumulator, the beat counter, and the output registers,
  // which are loaded on the edge that accepts the final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      ovf_acc  <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (start) begin
      len_q   <= len_new;
      acc     <= in_ext;
      cnt     <= ONE;
      ovf_acc <= 1'b0;
      if (len_new == ONE) begin
        out_data <= in_ext;
        out_ovf  <= 1'b0;
      end
    end else if (accept) begin
      acc     <= acc_nxt;
      cnt     <= cnt_inc;
      ovf_acc <= ovf_acc | ovf;
      if (last) begin
        out_data <= acc_nxt;
        out_ovf  <= ovf_acc | ovf;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator. It uses ACC_W=34 so that the overflow
// case fits alongside the other windows.
module tb_psum_accumulator;
  localparam int IN_W = 32, ACC_W = 34, LEN_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LEN_W-1:0]        cfg_len;
  logic                    in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
  logic signed [IN_W-1:0]  in_data;
  logic signed [ACC_W-1:0] out_data;

  int checks = 0, errors = 0, early;

  psum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic signed [IN_W-1:0] d);
    in_valid = 1'b1; in_data = d; step();
  endtask

  initial begin
    rst = 1'b1; cfg_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // 1: window of 4
    cfg_len = 8'd4;
    beat(10);   chk("t1_busy_b2", busy, 1);
    chk("t1_novalid", out_valid, 0);
    beat(-3);   beat(7);
    chk("t1_busy_b4", busy, 1);
    beat(100);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 114);
    chk("t1_ovf", out_ovf, 0);
    chk("t1_busy_done", busy, 0);
    in_valid = 1'b0; step();
    chk("t1_drain", out_valid, 0);

    // 2: len=1 streaming at full rate
    cfg_len = 8'd1;
    beat(-5);
    chk("t2_rdy0", in_ready, 1); chk("t2_v0", out_valid, 1); chk("t2_d0", out_data, -5);
    beat(6);
    chk("t2_rdy1", in_ready, 1); chk("t2_v1", out_valid, 1); chk("t2_d1", out_data, 6);
    beat(-7);
    chk("t2_v2", out_valid, 1); chk("t2_d2", out_data, -7);
    in_valid = 1'b0; step();
    chk("t2_drain", out_valid, 0);

    // 3: backpressure, then a same-cycle restart; a mid-window cfg change is ignored
    cfg_len = 8'd2; out_ready = 1'b0;
    beat(3); beat(4);
    in_data = 9;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_rdy", in_ready, 0);
      chk("t3_hold_v", out_valid, 1);
      chk("t3_hold_d", out_data, 7);
      step();
    end
    out_ready = 1'b1; #1;
    chk("t3_release_rdy", in_ready, 1);
    step();
    chk("t3_restart_busy", busy, 1);
    chk("t3_restart_v", out_valid, 0);
    cfg_len = 8'd5;
    beat(1);
    chk("t3_win2_v", out_valid, 1);
    chk("t3_win2_d", out_data, 10);
    in_valid = 1'b0; step();

    // 4: overflow across 5 max-positive beats
    cfg_len = 8'd5;
    for (int i = 0; i < 5; i++) beat(32'sh7FFFFFFF);
    chk("t4_v", out_valid, 1);
`ifdef PSUM_ACC_SAT_EN
    chk("t4_data", out_data, 64'sd8589934591);
`else
    chk("t4_data", out_data, -64'sd6442450949);
`endif
    chk("t4_ovf", out_ovf, 1);
    in_valid = 1'b0; step();

    // 5: reset mid-window discards the partial sum
    cfg_len = 8'd4;
    beat(1); beat(2);
    in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    chk("t5_rst_v", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    beat(1); beat(2); beat(3);
    chk("t5_novalid", out_valid, 0);
    beat(4);
    chk("t5_v", out_valid, 1);
    chk("t5_data", out_data, 10);
    chk("t5_ovf", out_ovf, 0);
    in_valid = 1'b0; step();

    // 6: cfg_len=0 means 256 beats
    cfg_len = 8'd0; early = 0;
    for (int i = 0; i < 255; i++) begin
      beat(1);
      if (out_valid) early++;
    end
    chk("t6_early", early, 0);
    beat(1);
    chk("t6_v", out_valid, 1);
    chk("t6_data", out_data, 256);
    chk("t6_ovf", out_ovf, 0);
    in_valid = 1'b0; step();
    chk("t6_drain", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
